// File: rtl/ps2_key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_pkg
// Purpose  : Shared constants for the PS/2 Set-2 key decoder: prefix and
//            game-key scancodes, the ignore set, key bit indices, the
//            decoder state encoding and small lookup helpers.
// Revision : 1.0  initial release
// ============================================================================
package ps2_key_pkg;

    // Prefix bytes of the Set-2 protocol
    localparam logic [7:0] PREFIX_E0 = 8'hE0;
    localparam logic [7:0] PREFIX_F0 = 8'hF0;

    // Game-key scancodes (the arrow keys only map when E0-prefixed)
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Keyboard status / response bytes that never form an event from IDLE
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] SC_OVRRUN0  = 8'h00;
    localparam logic [7:0] SC_OVRRUN1  = 8'hFF;

    // Bit positions in keys_held / keys_press
    localparam int KEY_SPACE = 0;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_LEFT  = 3;
    localparam int KEY_RIGHT = 4;
    localparam int NUM_KEYS  = 5;

    // Decoder state: which prefixes of the current sequence have been seen
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } ps2_state_t;

    // True for bytes that are silently dropped when no sequence is open
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == SC_BAT_OK)   || (b == SC_ACK)     || (b == SC_ECHO) ||
               (b == SC_BAT_FAIL) || (b == SC_OVRRUN0) || (b == SC_OVRRUN1);
    endfunction

    // One-hot key vector for a decoded code; zero for unmapped keys.
    // The extended flag must match exactly (keypad 8 = 0x75 without E0).
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [7:0] code,
                                                       input logic       ext);
        logic [NUM_KEYS-1:0] v;
        v = '0;
        if (!ext && code == SC_SPACE) v[KEY_SPACE] = 1'b1;
        if ( ext && code == SC_UP)    v[KEY_UP]    = 1'b1;
        if ( ext && code == SC_DOWN)  v[KEY_DOWN]  = 1'b1;
        if ( ext && code == SC_LEFT)  v[KEY_LEFT]  = 1'b1;
        if ( ext && code == SC_RIGHT) v[KEY_RIGHT] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Turns the PS/2 byte stream into make/break events, tracks the
//            held state of the five game keys and emits one-cycle press
//            pulses with typematic repeat suppressed. Abandons a prefixed
//            sequence after TIMEOUT_CYCLES idle clocks.
// Revision : 1.0  initial release
// ============================================================================
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 17
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7:0]          key_data,
    input  logic                key_pressed,
    output logic                evt_valid,
    output logic [7:0]          evt_code,
    output logic                evt_ext,
    output logic                evt_break,
    output logic [NUM_KEYS-1:0] keys_held,
    output logic [NUM_KEYS-1:0] keys_press,
    output logic                control,
    output logic                seq_error
);

    // The counter value present in the cycle where the sequence is dropped;
    // the increment in that cycle brings it to TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] c_EXPIRE_AT = TO_W'(TIMEOUT_CYCLES - 2);

    ps2_state_t          r_state;
    ps2_state_t          w_next_state;
    logic [TO_W-1:0]     r_cnt;
    logic                w_expire;
    logic                w_emit;
    logic                w_ext;
    logic                w_brk;
    logic                w_err;
    logic [NUM_KEYS-1:0] w_hit;
    logic [NUM_KEYS-1:0] w_held_next;
    logic [NUM_KEYS-1:0] w_press_next;

    // A byte always wins over expiry, so expiry is only considered on idle cycles
    assign w_expire = (r_state != ST_IDLE) && !key_pressed && (r_cnt == c_EXPIRE_AT);

    // Next-state and event decode for the byte presented this cycle
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_ext        = 1'b0;
        w_brk        = 1'b0;
        w_err        = 1'b0;
        if (key_pressed) begin
            case (r_state)
                ST_IDLE: begin
                    if (key_data == PREFIX_E0) begin
                        w_next_state = ST_E0;
                    end else if (key_data == PREFIX_F0) begin
                        w_next_state = ST_F0;
                    end else if (!is_ignored(key_data)) begin
                        w_emit = 1'b1;
                    end
                end
                ST_E0: begin
                    if (key_data == PREFIX_F0) begin
                        w_next_state = ST_E0F0;
                    end else if (key_data == PREFIX_E0) begin
                        w_next_state = ST_E0;
                    end else begin
                        w_emit       = 1'b1;
                        w_ext        = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    // ST_F0 / ST_E0F0: a prefix here restarts the sequence
                    if (key_data == PREFIX_E0) begin
                        w_err        = 1'b1;
                        w_next_state = ST_E0;
                    end else if (key_data == PREFIX_F0) begin
                        w_err        = 1'b1;
                        w_next_state = ST_F0;
                    end else begin
                        w_emit       = 1'b1;
                        w_brk        = 1'b1;
                        w_ext        = (r_state == ST_E0F0);
                        w_next_state = ST_IDLE;
                    end
                end
            endcase
        end else if (w_expire) begin
            w_next_state = ST_IDLE;
        end
    end

    // Key-vector update: breaks clear, makes set and pulse only on first make
    always_comb begin
        w_hit        = w_emit ? key_onehot(key_data, w_ext) : '0;
        w_held_next  = keys_held;
        w_press_next = '0;
        if (w_brk) begin
            w_held_next = keys_held & ~w_hit;
        end else begin
            w_held_next  = keys_held | w_hit;
            w_press_next = w_hit & ~keys_held;
        end
    end

    // Idle timer: runs only while a sequence is open and no byte arrives
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE || key_pressed) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sequence state and all registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            evt_valid  <= 1'b0;
            evt_code   <= '0;
            evt_ext    <= 1'b0;
            evt_break  <= 1'b0;
            keys_held  <= '0;
            keys_press <= '0;
            control    <= 1'b0;
            seq_error  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            evt_valid  <= w_emit;
            if (w_emit) begin
                evt_code  <= key_data;
                evt_ext   <= w_ext;
                evt_break <= w_brk;
            end
            keys_held  <= w_held_next;
            keys_press <= w_press_next;
            control    <= w_held_next[KEY_SPACE];
            seq_error  <= seq_error | w_err;
        end
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the byte stream from the PS/2 keyboard interface (`ps2_key_data` and `ps2_key_pressed`) and turns raw Set-2 scancodes into make/break key events. It tracks the held state of the game keys and produces one-cycle press pulses with typematic auto-repeat suppressed. It sits between `PS2_Interface` and `vga_controller`; its `control` output drives the VGA/game `control` input in place of the board switch.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100000. Idle clocks allowed after a prefix byte before the decoder abandons the sequence (2 ms at 50 MHz).
- `TO_W`, default 17. Timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- `clock`  in  1  system clock (50 MHz).
- `resetn`  in  1  asynchronous, active-low reset.
- `key_data`  in  8  received scancode byte; valid only while `key_pressed`=1.
- `key_pressed`  in  1  one-cycle strobe, one per received byte.
- `evt_valid`  out  1  one-cycle strobe: a complete make/break event was decoded.
- `evt_code`  out  8  scancode of the event, prefixes stripped.
- `evt_ext`  out  1  event carried the E0 prefix.
- `evt_break`  out  1  1 = release, 0 = press.
- `keys_held`  out  5  held level per key: [0] space, [1] up, [2] down, [3] left, [4] right.
- `keys_press`  out  5  one-cycle pulse on the first make of each key, same bit order as `keys_held`.
- `control`  out  1  equals `keys_held[0]` (space held).
- `seq_error`  out  1  sticky; set on a protocol error, cleared only by reset.

## Operation
- Reset values: all outputs 0; FSM state is IDLE; timeout counter is 0.
- FSM states: IDLE, E0, F0, E0F0. Transitions happen only on `key_pressed` or on timeout.
  - IDLE: 0xE0 → E0. 0xF0 → F0. 0xAA, 0xFA, 0xEE, 0xFC, 0x00 and 0xFF are ignored (no event). Any other byte emits a make with ext=0 and stays in IDLE.
  - E0: 0xF0 → E0F0. 0xE0 stays in E0. Any other byte emits a make with ext=1 → IDLE.
  - F0: any non-prefix byte emits a break with ext=0 → IDLE. 0xE0 or 0xF0 sets `seq_error` and goes to E0 or F0 respectively, restarting the sequence.
  - E0F0: any non-prefix byte emits a break with ext=1 → IDLE. A prefix byte sets `seq_error` and restarts as in F0.
- Key mapping:
  - space: 0x29 with ext=0.
  - up: 0x75 with ext=1.
  - down: 0x72 with ext=1.
  - left: 0x6B with ext=1.
  - right: 0x74 with ext=1.
  - Same code with the wrong ext value (e.g. keypad 0x75, ext=0) does not map to any key.
- On a make of a mapped key:
  - `keys_press[i]` pulses only if `keys_held[i]` was 0.
  - `keys_held[i]` is then set to 1.
  - Repeat makes while held emit `evt_valid` but no `keys_press` pulse.
- On a break of a mapped key, `keys_held[i]` is cleared. A break of a key that is not held is harmless.
- Unmapped keys still produce `evt_*` outputs but do not touch the key vectors.
- Pause/PrintScreen multi-byte sequences decode as ordinary events; no special handling.

## Timing
- All outputs are registered.
- An event completed by a byte strobed in cycle N appears on `evt_*`, `keys_press` and `keys_held` in cycle N+1.
- `evt_valid` and `keys_press` are high for exactly one cycle.
- Timeout counter:
  - Counts while the state is not IDLE and `key_pressed`=0.
  - Clears on every `key_pressed` and whenever the state is IDLE.
  - On reaching TIMEOUT_CYCLES−1, the FSM returns to IDLE with no event and no `seq_error`.
- If `key_pressed` and expiry coincide, the byte wins: it is decoded in the current state and the counter clears.
- `key_pressed` strobes in consecutive cycles are legal and each byte is processed; the decoder has no stall.
- Reset asserted mid-sequence drops the partial sequence and clears all held keys immediately (asynchronous).

## Structure
- Package `ps2_key_pkg` holds:
  - scancode constants: PREFIX_E0, PREFIX_F0, SC_SPACE, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, and the ignore set;
  - key index constants KEY_SPACE through KEY_RIGHT;
  - the 2-bit FSM state encoding.
- Single module; no sub-module. The timeout counter is inline.

## Test plan
- Bytes 29, F0, 29 (on separate strobes) → make event (29, ext 0, brk 0) with `keys_press[0]` pulse and `control`=1. Then break event (29, ext 0, brk 1) and `control`=0.
- Bytes E0 75, E0 75, E0 75, then E0 F0 75 → a single `keys_press[1]` pulse, 3 make events, `keys_held[1]` high until the break, then low.
- Byte E0, then 100000 idle clocks, then 29 → no event from E0; 29 decodes as a plain make (ext 0); `seq_error`=0.
- Byte E0, then 29 strobed on cycle 99999 (coincident with expiry) → make event with ext=1.
- Bytes F0, E0, F0, 6B → `seq_error`=1; break event for left (6B, ext 1).
- Hold space and up, then assert `resetn`=0 mid-sequence (after F0) → all outputs 0 asynchronously. After release, byte 29 decodes as a fresh make.
